// File: rtl/cfifo_pkg.sv
// Shared definitions for the two-stage token FIFO controller.
// Holds the stage count, the register reset values and the event bundle type.
package cfifo_pkg;

  localparam int unsigned CFIFO_STAGES = 2;

  // Reset values for the occupancy flags, the edge-detector history bits and the output pulses.
  localparam logic FULL_RST   = 1'b0;
  localparam logic EDGE_Q_RST = 1'b0;
  localparam logic PULSE_RST  = 1'b0;
  localparam logic [CFIFO_STAGES-1:0] FIRE_RST = '0;

  // Rising-edge events seen this cycle on the two handshake inputs.
  typedef struct packed {
    logic drive;
    logic free_next;
  } cfifo_ev_t;

endpackage

// File: rtl/c_fifo2_cache_if.sv
// Handshake bundle for c_fifo2_cache.
// master: upstream/downstream environment (drives i_drive, i_freeNext).
// slave : the FIFO controller (drives o_free, o_driveNext, o_fire_2).
interface c_fifo2_cache_if;

  logic                                   i_drive;
  logic                                   i_freeNext;
  logic                                   o_free;
  logic                                   o_driveNext;
  logic [cfifo_pkg::CFIFO_STAGES-1:0]     o_fire_2;

  modport master (
    output i_drive,
    output i_freeNext,
    input  o_free,
    input  o_driveNext,
    input  o_fire_2
  );

  modport slave (
    input  i_drive,
    input  i_freeNext,
    output o_free,
    output o_driveNext,
    output o_fire_2
  );

endinterface

// File: rtl/cfifo_edge_det.sv
// One-bit rising-edge detector.
// Ports: clk, rstn (async active-low), sig (level input), ev_c (combinational
// pulse, high while sig is 1 and was 0 at the previous clock edge).
module cfifo_edge_det
  import cfifo_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic sig,
  output logic ev_c
);

  logic sig_q;

  // Previous sample of the level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig_q <= EDGE_Q_RST;
    end else begin
      sig_q <= sig;
    end
  end

  assign ev_c = sig & ~sig_q;

endmodule

// File: rtl/c_fifo2_cache.sv
// Two-stage token FIFO controller (synchronous click-style FIFO).
// Tracks tokens through two occupancy flags and emits per-stage capture
// strobes for an external data path; carries no data itself.
// Ports: clk, rstn (async active-low), bus (c_fifo2_cache_if.slave):
//   i_drive / i_freeNext : upstream request / downstream acknowledge levels
//   o_free / o_driveNext : one-cycle pulses upstream / downstream
//   o_fire_2             : one-cycle capture strobes, bit n latches stage n
module c_fifo2_cache
  import cfifo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  c_fifo2_cache_if.slave         bus
);

  cfifo_ev_t ev_c;

  logic full0;
  logic full1;
  logic full0_d;
  logic full1_d;

  logic rel_c;
  logic mv_c;
  logic acc_c;

  logic                    free_q;
  logic                    drive_next_q;
  logic [CFIFO_STAGES-1:0] fire_q;
  logic                    free_d;
  logic                    drive_next_d;
  logic [CFIFO_STAGES-1:0] fire_d;

  cfifo_edge_det u_drive_det (
    .clk  (clk),
    .rstn (rstn),
    .sig  (bus.i_drive),
    .ev_c (ev_c.drive)
  );

  cfifo_edge_det u_free_next_det (
    .clk  (clk),
    .rstn (rstn),
    .sig  (bus.i_freeNext),
    .ev_c (ev_c.free_next)
  );

  // Release, advance and accept decisions plus next flag/pulse values.
  always_comb begin
    full0_d      = full0;
    full1_d      = full1;
    free_d       = 1'b0;
    drive_next_d = 1'b0;
    fire_d       = '0;

    rel_c = ev_c.free_next & full1;
    mv_c  = full0 & (~full1 | rel_c);
    // A drive while stage 0 stays occupied is dropped without any side effect.
    acc_c = ev_c.drive & (~full0 | mv_c);

    if (rel_c) begin
      full1_d = 1'b0;
    end
    if (mv_c) begin
      full1_d      = 1'b1;
      full0_d      = 1'b0;
      free_d       = 1'b1;
      drive_next_d = 1'b1;
      fire_d[1]    = 1'b1;
    end
    // Accept is applied last so a same-edge refill keeps stage 0 full.
    if (acc_c) begin
      full0_d   = 1'b1;
      fire_d[0] = 1'b1;
    end
  end

  // Occupancy flags and registered output pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full0        <= FULL_RST;
      full1        <= FULL_RST;
      free_q       <= PULSE_RST;
      drive_next_q <= PULSE_RST;
      fire_q       <= FIRE_RST;
    end else begin
      full0        <= full0_d;
      full1        <= full1_d;
      free_q       <= free_d;
      drive_next_q <= drive_next_d;
      fire_q       <= fire_d;
    end
  end

  assign bus.o_free      = free_q;
  assign bus.o_driveNext = drive_next_q;
  assign bus.o_fire_2    = fire_q;

endmodule

// File: tb/tb_c_fifo2_cache.sv
// Directed self-checking bench for c_fifo2_cache.
// Outputs are compared as {o_free, o_driveNext, o_fire_2[1:0]}.
module tb_c_fifo2_cache;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  c_fifo2_cache_if bus ();

  c_fifo2_cache dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {bus.o_free, bus.o_driveNext, bus.o_fire_2};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle high pulse on the selected inputs, then sample the cycle it caused.
  task automatic pulse(input logic drv, input logic frn, input string tag, input logic [3:0] exp);
    bus.i_drive    = drv;
    bus.i_freeNext = frn;
    tick();
    bus.i_drive    = 1'b0;
    bus.i_freeNext = 1'b0;
    chk(tag, outs(), exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    bus.i_drive    = 1'b0;
    bus.i_freeNext = 1'b0;

    // Reset held with inputs toggling: outputs must stay quiet.
    for (int i = 0; i < 150; i++) begin
      bus.i_drive    = 1'($urandom);
      bus.i_freeNext = 1'($urandom);
      tick();
      if (i % 25 == 0) chk("rst_hold", outs(), 4'b0000);
    end
    bus.i_drive    = 1'b0;
    bus.i_freeNext = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst0", outs(), 4'b0000);
    tick();
    chk("post_rst1", outs(), 4'b0000);

    // Single token: accept, then pass-through to stage 1.
    pulse(1'b1, 1'b0, "single_acc", 4'b0001);
    tick();
    chk("single_mv", outs(), 4'b1110);
    tick();
    chk("single_idle0", outs(), 4'b0000);
    tick();
    chk("single_idle1", outs(), 4'b0000);

    // Second token fills stage 0; stage 1 occupied so no advance.
    pulse(1'b1, 1'b0, "fill_acc", 4'b0001);
    tick();
    chk("fill_no_mv", outs(), 4'b0000);

    // Overflow drive is dropped silently.
    pulse(1'b1, 1'b0, "ovf0", 4'b0000);
    tick();
    chk("ovf1", outs(), 4'b0000);

    // Release from full: stage 1 refilled from stage 0 on the same edge.
    pulse(1'b0, 1'b1, "full_rel", 4'b1110);
    tick();
    chk("full_rel_idle", outs(), 4'b0000);
    // Only one token left: next release empties stage 1 with no advance.
    pulse(1'b0, 1'b1, "last_rel", 4'b0000);
    tick();
    // Release on empty stage 1 is ignored.
    pulse(1'b0, 1'b1, "rel_empty", 4'b0000);
    tick();

    // Held level counts once.
    bus.i_drive = 1'b1;
    tick();
    chk("hold_acc", outs(), 4'b0001);
    tick();
    chk("hold_mv", outs(), 4'b1110);
    tick();
    chk("hold_once", outs(), 4'b0000);
    bus.i_drive = 1'b0;
    tick();

    // Both stages full, then simultaneous drive and release.
    pulse(1'b1, 1'b0, "sim_fill", 4'b0001);
    tick();
    chk("sim_fill_idle", outs(), 4'b0000);
    pulse(1'b1, 1'b1, "simul", 4'b1111);
    tick();
    chk("simul_idle", outs(), 4'b0000);
    pulse(1'b0, 1'b1, "simul_rel", 4'b1110);
    tick();

    // Mid-operation reset with stage 1 full: outputs drop asynchronously.
    pulse(1'b1, 1'b0, "mid_acc", 4'b0001);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_async", outs(), 4'b0000);
    tick();
    tick();
    chk("mid_rst_hold", outs(), 4'b0000);
    rstn = 1'b1;
    tick();
    chk("mid_rst_rel", outs(), 4'b0000);
    pulse(1'b0, 1'b1, "mid_rel_none", 4'b0000);
    tick();
    chk("mid_rel_idle", outs(), 4'b0000);
    pulse(1'b1, 1'b0, "mid_single_acc", 4'b0001);
    tick();
    chk("mid_single_mv", outs(), 4'b1110);
    tick();
    chk("mid_single_idle", outs(), 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c_fifo2_cache.md
# c_fifo2_cache

Two-stage token FIFO controller for the cache subsystem's handshake pipeline. It is a synchronous re-implementation of a click-style two-stage FIFO. It tracks tokens through two stage registers and emits per-stage capture strobes (`o_fire_2`) that clock an external two-stage data path. It returns "free" pulses upstream and "drive" pulses downstream. It carries no data itself.

## Interface
- Parameters: none. Stage count fixed at 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rstn` input 1: reset, asynchronous and active-low. It clears all state immediately; release is synchronous to `clk`.
- `i_drive` input 1: upstream request; a new token is offered. Event = rising edge of the level, detected in `clk` domain.
- `i_freeNext` input 1: downstream acknowledge; downstream has consumed the stage-1 token. Event = rising edge.
- `o_free` output 1: one-cycle pulse to upstream; stage 0 has been vacated and may be driven again.
- `o_driveNext` output 1: one-cycle pulse to downstream; a new token is valid in stage 1.
- `o_fire_2` output 2: one-cycle capture strobes. Bit 0 latches stage-0 data; bit 1 latches stage-1 data (from stage 0).

## Operation
- State:
  - `full0` and `full1` occupancy flags.
  - `drv_q` and `frn_q`, the previous samples of `i_drive` and `i_freeNext`.
  - Registered output pulses.
- Event detection:
  - `drv_ev = i_drive & ~drv_q`.
  - `frn_ev = i_freeNext & ~frn_q`.
  - A level held high counts once.
- Stage-1 release: when `frn_ev & full1`, `full1` is cleared. `frn_ev` with `full1 = 0` is ignored.
- Advance (`mv`):
  - Condition: `mv = full0 & (~full1 | (frn_ev & full1))`.
  - On `mv`: `full1` is set, `full0` is cleared, and `o_fire_2[1]`, `o_driveNext` and `o_free` pulse.
- Accept (`acc`):
  - Condition: `acc = drv_ev & (~full0 | mv)`.
  - On `acc`: `full0` is set (overrides the clear from `mv`) and `o_fire_2[0]` pulses.
- Overflow: `drv_ev` while `full0 = 1` and no `mv` is a protocol violation. The token is dropped and no output changes.
- Upstream protocol: one `i_drive` after reset, then one per `o_free` pulse.
- Downstream protocol: one `i_freeNext` per `o_driveNext` pulse.

## Timing
- Reset values: all outputs are 0, and `full0`, `full1`, `drv_q`, `frn_q` are 0. Mid-operation reset discards all tokens; no pulses are generated on reset release.
- All outputs are registered. Each pulse is high for exactly one cycle, starting the cycle after the edge that caused it.
- Accept latency: `drv_ev` sampled at edge k, empty FIFO →
  - `o_fire_2 = 2'b01` during cycle k+1;
  - `o_fire_2 = 2'b10`, `o_driveNext = 1`, `o_free = 1` during cycle k+2.
- Pass-through: when `full0` is set and stage 1 is empty, the advance occurs one edge after the accept.
- Full-release latency: both stages full, `frn_ev` at edge m → `o_fire_2[1]`, `o_driveNext` and `o_free` high during cycle m+1. The release and the refill of stage 1 happen in the same edge.
- Simultaneous `drv_ev` and `mv` on one edge: both happen. `o_fire_2 = 2'b11` in the following cycle.
- Minimum spacing: separate edges need input low for ≥1 cycle between highs.

## Structure
- Shared package `cfifo_pkg`:
  - `CFIFO_STAGES = 2`.
  - Reset-value constants.
  - A `cfifo_ev_t` struct grouping `{drive, freeNext}` event bits.
- Sub-module `cfifo_edge_det`: a one-bit rising-edge detector with async active-low reset. Instantiate it twice, for `i_drive` and `i_freeNext`.
- The top level holds the stage flags, the `mv`/`acc` logic and the output registers.

## Test plan
- Reset: hold `rstn = 0` for 150 cycles while toggling inputs → all outputs stay 0. After release, no pulse appears before the first `i_drive`.
- Single token: `i_drive` pulse at edge k →
  - `o_fire_2 = 01` at k+1;
  - `o_fire_2 = 10` with `o_driveNext = 1` and `o_free = 1` at k+2;
  - then all 0 until `i_freeNext`.
- Fill both stages:
  - Two drives separated by `o_free`: the second drive gives `fire_2 = 01`, no advance, and `o_driveNext` silent.
  - `i_freeNext` pulse at edge m → `fire_2 = 10`, `o_driveNext = 1`, `o_free = 1` at m+1.
- Overflow: third `i_drive` while both stages are full and no `i_freeNext` → no output activity; occupancy unchanged (verified by a single subsequent advance).
- Simultaneous: both stages full, `i_drive` and `i_freeNext` rising on the same edge → next cycle `fire_2 = 11`, `o_driveNext = 1`, `o_free = 1`.
- Mid-operation reset: assert `rstn` low with `full1 = 1` → outputs drop to 0 asynchronously. After release, `i_freeNext` produces nothing and a new `i_drive` behaves as in the single-token case.
